// File: rtl/serie_paralelo_rx_pkg.sv
// Shared phy definitions: receiver FSM states
// and the idle/comma byte used on the serial link.
package serie_paralelo_rx_pkg;

  localparam logic [7:0] COM_BYTE = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/serie_paralelo_rx_com_detect.sv
// Serial-in shift register plus comma comparator.
// The newest bit enters at bit 0.
module com_detect
  import serie_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COM = COM_BYTE
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_inS,
  output logic [7:0] rx_byte,
  output logic       is_com
);

  always_ff @(posedge clk_8f) begin
    if (reset) rx_byte <= '0;
    else       rx_byte <= {rx_byte[6:0], data_inS};
  end

  assign is_com = (rx_byte == COM);

endmodule

// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: comma search, byte alignment,
// lock after LOCK_COUNT commas, then byte delivery.
module serie_paralelo_rx
  import serie_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COM        = COM_BYTE,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_inS,
  output logic [7:0] data_outP,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] com_cnt;
  logic [7:0]    rx_byte;
  logic          is_com;
  logic          boundary;

  com_detect #(
    .COM(COM)
  ) u_com_detect (
    .clk_8f  (clk_8f),
    .reset   (reset),
    .data_inS(data_inS),
    .rx_byte (rx_byte),
    .is_com  (is_com)
  );

  // rx_byte holds a whole aligned byte when the counter wraps
  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state     <= SEARCH;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_outP <= '0;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
      active    <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (is_com) begin
            state   <= (LOCK_COUNT <= 1) ? ACTIVE : ALIGN;
            active  <= (LOCK_COUNT <= 1);
            bit_cnt <= '0;
            com_cnt <= CW'(1);
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              if (com_cnt != LOCK_C)
                com_cnt <= com_cnt + 1'b1;
              if (com_cnt + 1'b1 >= LOCK_C) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            byte_stb <= 1'b1;
            if (is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_outP <= rx_byte;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
